mem_burst_master: RTL

- Initiator for the 16x8 synchronous memory. Drives its write port (we, write address, data in) and read port (re, read address, data out).
- Accepts burst commands from a valid/ready command channel.
- Streams write data in from a valid/ready write channel and streams read data out on a valid/ready read channel.
- Sits between bus/test logic and the memory; replaces hand-sequenced we/re stimulus.

---
 rtl/mem_burst_pkg.sv | 21 ++
 rtl/mem_burst_master_sat_counter.sv | 22 ++
 rtl/mem_burst_master.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the memory burst master.
// Contents: FSM state enum, default address/data widths, legal read-latency
// range, read-latency counter width and statistics counter width.
package mem_burst_pkg;

    localparam int unsigned AW_DEF     = 4;
    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned LAT_W      = $clog2(RD_LAT_MAX + 1);
    localparam int unsigned STAT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } state_t;

endpackage

// File: rtl/mem_burst_master_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Ports: clk, rst (async, active-high), inc (count one event this cycle),
//        count (current value, resets to 0).
module mem_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events until every bit is set, then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for a small synchronous memory. Takes burst commands on a
// valid/ready channel, streams write beats into the memory write port and
// streams read beats out of the memory read port.
// Ports:
//   clk, rst                        clock, async active-high reset
//   cmd_valid/ready/write/addr/len  burst command (len = beats - 1)
//   wr_valid/ready/data             write beat channel
//   rd_valid/ready/data/last        read beat channel (registered data/last)
//   busy                            a burst is in progress
//   mem_we/waddr/wdata              memory write port
//   mem_re/raddr/rdata              memory read port (RD_LAT cycle latency)
// Optional: define MEM_BURST_MASTER_STATS_EN to add saturating beat counters
//   stat_wr_beats / stat_rd_beats.
module mem_burst_master
    import mem_burst_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_BURST_MASTER_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_wr_beats,
    output logic [STAT_W-1:0] stat_rd_beats
`endif
);

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [DW-1:0]    rd_data_d;
    logic             rd_valid_d;
    logic             rd_last_d;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            lat_q    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            rd_last  <= rd_last_d;
        end
    end

    // Next state, datapath updates and the combinational handshake/memory strobes.
    // The memory strobes decode straight from the state register so that an
    // async reset drops them immediately.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        rd_data_d  = rd_data;
        rd_valid_d = rd_valid;
        rd_last_d  = rd_last;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr_q;
        mem_wdata  = wr_data;
        mem_re     = 1'b0;
        mem_raddr  = addr_q;
        busy       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? WR : RD_ISSUE;
                end
            end
            WR: begin
                wr_ready = 1'b1;
                mem_we   = wr_valid;
                if (wr_valid) begin
                    addr_d = addr_q + AW'(1);
                    cnt_d  = cnt_q - AW'(1);
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_ISSUE: begin
                mem_re  = 1'b1;
                lat_d   = LAT_W'(RD_LAT);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // lat_q == 1 marks the cycle whose closing edge sees valid read data.
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    rd_data_d  = mem_rdata;
                    rd_last_d  = (cnt_q == '0);
                    rd_valid_d = 1'b1;
                    state_d    = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        cnt_d   = cnt_q - AW'(1);
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MEM_BURST_MASTER_STATS_EN
    // Beat statistics: one write per mem_we cycle, one read per rd handshake.
    logic rd_beat_c;
    assign rd_beat_c = rd_valid & rd_ready;

    mem_sat_counter #(.W(STAT_W)) u_stat_wr (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_we),
        .count (stat_wr_beats)
    );

    mem_sat_counter #(.W(STAT_W)) u_stat_rd (
        .clk   (clk),
        .rst   (rst),
        .inc   (rd_beat_c),
        .count (stat_rd_beats)
    );
`endif

endmodule
